// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge control FSM: turns decoded AHB transfers into
// APB setup/enable pairs, pipelining back-to-back writes.
module apb_fsm_controller (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        valid,
  input  logic [31:0] Haddr,
  input  logic [31:0] Haddr1,
  input  logic [31:0] Hwdata,
  input  logic        Hwrite,
  input  logic        Hwritereg,
  input  logic [2:0]  tempselx,
  input  logic [31:0] Prdata,
  output logic        Pwrite,
  output logic        Penable,
  output logic [2:0]  Pselx,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic        Hreadyout,
  output logic [31:0] Hrdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_READ,
    ST_RENABLE,
    ST_WRITE,
    ST_WRITEP,
    ST_WENABLE,
    ST_WENABLEP
  } state_t;

  state_t      state, state_n;
  logic        pwrite_n, penable_n, hready_n;
  logic [2:0]  psel_n;
  logic [31:0] paddr_n, pwdata_n;

  assign Hrdata = Prdata;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE, ST_WENABLE, ST_RENABLE: begin
        unique case (1'b1)
          valid && Hwrite:  state_n = ST_WWAIT;
          valid && !Hwrite: state_n = ST_READ;
          default:          state_n = ST_IDLE;
        endcase
      end
      ST_WWAIT:
        state_n = valid ? ST_WRITEP : ST_WRITE;
      ST_WRITE:
        state_n = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:
        state_n = ST_WENABLEP;
      ST_READ:
        state_n = ST_RENABLE;
      ST_WENABLEP: begin
        unique case (1'b1)
          !Hwritereg:         state_n = ST_READ;
          Hwritereg && valid: state_n = ST_WRITEP;
          default:            state_n = ST_WRITE;
        endcase
      end
    endcase
  end

  // Outputs are decided by the state being entered, so they
  // change on the same edge as the state register.
  always_comb begin
    psel_n    = Pselx;
    pwrite_n  = Pwrite;
    penable_n = Penable;
    paddr_n   = Paddr;
    pwdata_n  = Pwdata;
    hready_n  = Hreadyout;
    unique case (state_n)
      ST_READ: begin
        psel_n    = tempselx;
        pwrite_n  = 1'b0;
        penable_n = 1'b0;
        hready_n  = 1'b0;
        paddr_n   = (state == ST_WENABLEP) ? Haddr1 : Haddr;
      end
      ST_WRITE, ST_WRITEP: begin
        psel_n    = tempselx;
        pwrite_n  = 1'b1;
        penable_n = 1'b0;
        paddr_n   = Haddr1;
        pwdata_n  = Hwdata;
        hready_n  = 1'b0;
      end
      ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
        penable_n = 1'b1;
        hready_n  = 1'b1;
      end
      ST_WWAIT: begin
        penable_n = 1'b0;
        hready_n  = 1'b1;
      end
      ST_IDLE: begin
        psel_n    = 3'b000;
        penable_n = 1'b0;
        hready_n  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= ST_IDLE;
      Pselx     <= 3'b000;
      Pwrite    <= 1'b0;
      Penable   <= 1'b0;
      Paddr     <= 32'h0;
      Pwdata    <= 32'h0;
      Hreadyout <= 1'b1;
    end else begin
      state     <= state_n;
      Pselx     <= psel_n;
      Pwrite    <= pwrite_n;
      Penable   <= penable_n;
      Paddr     <= paddr_n;
      Pwdata    <= pwdata_n;
      Hreadyout <= hready_n;
    end
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Bench for apb_fsm_controller: directed AHB beats, APB transfer
// scoreboard and setup/enable protocol monitor.
module tb_apb_fsm_controller;

  logic        Hclk;
  logic        Hresetn;
  logic        valid;
  logic [31:0] Haddr, Haddr1, Hwdata;
  logic        Hwrite, Hwritereg;
  logic [2:0]  tempselx;
  logic [31:0] Prdata;
  logic        Pwrite, Penable, Hreadyout;
  logic [2:0]  Pselx;
  logic [31:0] Paddr, Pwdata, Hrdata;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t sbq[$];
  int    n_chk = 0;
  int    n_err = 0;

  logic        pv_en, pv_wr;
  logic [2:0]  pv_sel;
  logic [31:0] pv_addr, pv_wdata;

  apb_fsm_controller dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .valid     (valid),
    .Haddr     (Haddr),
    .Haddr1    (Haddr1),
    .Hwdata    (Hwdata),
    .Hwrite    (Hwrite),
    .Hwritereg (Hwritereg),
    .tempselx  (tempselx),
    .Prdata    (Prdata),
    .Pwrite    (Pwrite),
    .Penable   (Penable),
    .Pselx     (Pselx),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Hreadyout (Hreadyout),
    .Hrdata    (Hrdata)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] s, input logic [31:0] a,
                      input logic w, input logic [31:0] d);
    xfer_t x;
    x.sel = s; x.addr = a; x.wr = w; x.wdata = d;
    sbq.push_back(x);
  endtask

  // One AHB cycle; Haddr1/Hwritereg are the previous cycle's values.
  task automatic drive(input logic v, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] s);
    Haddr1    = Haddr;
    Hwritereg = Hwrite;
    valid     = v;
    Hwrite    = w;
    Haddr     = a;
    Hwdata    = d;
    tempselx  = s;
    Prdata    = $urandom;
    @(posedge Hclk);
    #1;
  endtask

  always @(negedge Hclk) begin
    if (!Hresetn) begin
      pv_en    <= 1'b0;
      pv_wr    <= 1'b0;
      pv_sel   <= 3'b000;
      pv_addr  <= 32'h0;
      pv_wdata <= 32'h0;
    end else begin
      if (Penable) begin
        chk("pen_twice", 32'(pv_en), 32'd0);
        chk("psel_stable", 32'(Pselx), 32'(pv_sel));
        chk("paddr_stable", Paddr, pv_addr);
        chk("pwrite_stable", 32'(Pwrite), 32'(pv_wr));
        chk("pwdata_stable", Pwdata, pv_wdata);
        if (sbq.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          chk("sb_sel", 32'(Pselx), 32'(sbq[0].sel));
          chk("sb_addr", Paddr, sbq[0].addr);
          chk("sb_wr", 32'(Pwrite), 32'(sbq[0].wr));
          if (sbq[0].wr)
            chk("sb_wdata", Pwdata, sbq[0].wdata);
          else
            chk("sb_hrdata", Hrdata, Prdata);
          sbq.delete(0);
        end
      end
      pv_en    <= Penable;
      pv_wr    <= Pwrite;
      pv_sel   <= Pselx;
      pv_addr  <= Paddr;
      pv_wdata <= Pwdata;
    end
  end

  initial begin
    Hresetn   = 1'b1;
    valid     = 1'b0;
    Haddr     = 32'h0;
    Haddr1    = 32'h0;
    Hwdata    = 32'h0;
    Hwrite    = 1'b0;
    Hwritereg = 1'b0;
    tempselx  = 3'b000;
    Prdata    = 32'h0;
    #2 Hresetn = 1'b0;
    #1;
    chk("rst_psel", 32'(Pselx), 32'd0);
    chk("rst_pen", 32'(Penable), 32'd0);
    chk("rst_pwrite", 32'(Pwrite), 32'd0);
    chk("rst_paddr", Paddr, 32'h0);
    chk("rst_pwdata", Pwdata, 32'h0);
    chk("rst_hready", 32'(Hreadyout), 32'd1);
    repeat (2) @(posedge Hclk);
    #1 Hresetn = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 3'b000);

    // single read
    push(3'b001, 32'h8000_0010, 1'b0, 32'h0);
    drive(1, 0, 32'h8000_0010, 32'h0, 3'b001);
    chk("rd_paddr", Paddr, 32'h8000_0010);
    chk("rd_psel", 32'(Pselx), 32'd1);
    chk("rd_pwrite", 32'(Pwrite), 32'd0);
    chk("rd_pen0", 32'(Penable), 32'd0);
    chk("rd_hready0", 32'(Hreadyout), 32'd0);
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    chk("rd_pen1", 32'(Penable), 32'd1);
    chk("rd_hready1", 32'(Hreadyout), 32'd1);
    chk("rd_hrdata", Hrdata, Prdata);
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    chk("rd_idle_psel", 32'(Pselx), 32'd0);
    chk("rd_idle_pen", 32'(Penable), 32'd0);

    // single write
    push(3'b100, 32'h8400_0004, 1'b1, 32'hDEAD_BEEF);
    drive(1, 1, 32'h8400_0004, 32'h0, 3'b100);
    chk("wr_wait_hready", 32'(Hreadyout), 32'd1);
    chk("wr_wait_pen", 32'(Penable), 32'd0);
    chk("wr_wait_psel", 32'(Pselx), 32'd0);
    drive(0, 0, 32'h0, 32'hDEAD_BEEF, 3'b100);
    chk("wr_paddr", Paddr, 32'h8400_0004);
    chk("wr_pwdata", Pwdata, 32'hDEAD_BEEF);
    chk("wr_pwrite", 32'(Pwrite), 32'd1);
    chk("wr_psel", 32'(Pselx), 32'd4);
    chk("wr_hready0", 32'(Hreadyout), 32'd0);
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    chk("wr_pen1", 32'(Penable), 32'd1);
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    chk("wr_idle_psel", 32'(Pselx), 32'd0);

    // pipelined burst of three writes
    push(3'b010, 32'h8800_0000, 1'b1, 32'h1111_1111);
    push(3'b010, 32'h8800_0004, 1'b1, 32'h2222_2222);
    push(3'b010, 32'h8800_0008, 1'b1, 32'h3333_3333);
    drive(1, 1, 32'h8800_0000, 32'h0, 3'b010);
    chk("bw_wwait_pen", 32'(Penable), 32'd0);
    drive(1, 1, 32'h8800_0004, 32'h1111_1111, 3'b010);
    chk("bw_p0_addr", Paddr, 32'h8800_0000);
    chk("bw_p0_hready", 32'(Hreadyout), 32'd0);
    drive(1, 1, 32'h8800_0004, 32'h1111_1111, 3'b010);
    chk("bw_e0_pen", 32'(Penable), 32'd1);
    drive(1, 1, 32'h8800_0008, 32'h2222_2222, 3'b010);
    chk("bw_p1_addr", Paddr, 32'h8800_0004);
    chk("bw_p1_pen", 32'(Penable), 32'd0);
    drive(1, 1, 32'h8800_0008, 32'h2222_2222, 3'b010);
    chk("bw_e1_pen", 32'(Penable), 32'd1);
    drive(0, 0, 32'h0, 32'h3333_3333, 3'b010);
    chk("bw_p2_addr", Paddr, 32'h8800_0008);
    chk("bw_p2_wdata", Pwdata, 32'h3333_3333);
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    chk("bw_e2_pen", 32'(Penable), 32'd1);
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    chk("bw_idle_psel", 32'(Pselx), 32'd0);

    // write followed by read out of WENABLEP
    push(3'b001, 32'h8C00_0100, 1'b1, 32'hCAFE_F00D);
    push(3'b001, 32'h8C00_0200, 1'b0, 32'h0);
    drive(1, 1, 32'h8C00_0100, 32'h0, 3'b001);
    drive(1, 0, 32'h8C00_0200, 32'hCAFE_F00D, 3'b001);
    chk("wrd_w_addr", Paddr, 32'h8C00_0100);
    chk("wrd_w_pwrite", 32'(Pwrite), 32'd1);
    drive(1, 0, 32'h8C00_0200, 32'hCAFE_F00D, 3'b001);
    chk("wrd_w_pen", 32'(Penable), 32'd1);
    drive(0, 0, 32'h0, 32'h0, 3'b001);
    chk("wrd_r_addr", Paddr, 32'h8C00_0200);
    chk("wrd_r_pwrite", 32'(Pwrite), 32'd0);
    chk("wrd_r_hready", 32'(Hreadyout), 32'd0);
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    chk("wrd_r_pen", 32'(Penable), 32'd1);
    drive(0, 0, 32'h0, 32'h0, 3'b000);

    // reset asserted during a read enable cycle
    drive(1, 0, 32'h8000_0030, 32'h0, 3'b001);
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    chk("ra_pre_pen", 32'(Penable), 32'd1);
    Hresetn = 1'b0;
    #1;
    chk("ra_pen", 32'(Penable), 32'd0);
    chk("ra_psel", 32'(Pselx), 32'd0);
    chk("ra_hready", 32'(Hreadyout), 32'd1);
    chk("ra_paddr", Paddr, 32'h0);
    @(posedge Hclk);
    #1 Hresetn = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    chk("ra_idle_psel", 32'(Pselx), 32'd0);
    chk("ra_idle_hready", 32'(Hreadyout), 32'd1);
    push(3'b001, 32'h8000_0020, 1'b0, 32'h0);
    drive(1, 0, 32'h8000_0020, 32'h0, 3'b001);
    chk("ra_rd_paddr", Paddr, 32'h8000_0020);
    chk("ra_rd_hready", 32'(Hreadyout), 32'd0);
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    chk("ra_rd_pen", 32'(Penable), 32'd1);
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    drive(0, 0, 32'h0, 32'h0, 3'b000);

    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end

endmodule
